// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass and a per-register
// pending (busy) scoreboard. Index 0 is hardwired to zero and never busy.
module regfile_sb #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 5,
  parameter int                NUM_RD  = 2,
  parameter int                SP_IDX  = 29,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h0000_0400),
  parameter bit                BYPASS  = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [1:NREG-1];
  logic [DATA_W-1:0] mem_d [1:NREG-1];
  logic [NREG-1:1]   busy_q;
  logic [NREG-1:1]   busy_d;

  // Reserve is applied after write so a same-index reservation wins the busy bit.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (wr_en && wr_addr == ADDR_W'(i)) begin
        mem_d[i]  = wr_data;
        busy_d[i] = 1'b0;
      end
      if (rsv_en && rsv_addr == ADDR_W'(i)) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREG; i++) begin
        mem_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  // Address 0 falls through to the zero defaults; bypass is blocked during reset.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int i = 1; i < NREG; i++) begin
        if (rd_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
          rd_data[k*DATA_W +: DATA_W] = mem_q[i];
          rd_busy[k]                  = busy_q[i];
        end
      end
      if (BYPASS && !reset && wr_en && wr_addr != '0 &&
          wr_addr == rd_addr[k*ADDR_W +: ADDR_W]) begin
        rd_data[k*DATA_W +: DATA_W] = wr_data;
        rd_busy[k]                  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: a 4-port bypassing instance
// and a 2-port non-bypassing instance share the write/reserve stimulus.
module tb_regfile_sb;

  logic        clk;
  logic        reset;
  logic [19:0] rd_addr;
  logic [127:0] rd_data;
  logic [3:0]  rd_busy;
  logic [63:0] rd_data_nb;
  logic [1:0]  rd_busy_nb;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  int errors;
  int checks;

  regfile_sb #(.NUM_RD(4), .BYPASS(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr)
  );

  regfile_sb #(.NUM_RD(2), .BYPASS(1'b0)) dut_nb (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr[9:0]),
    .rd_data  (rd_data_nb),
    .rd_busy  (rd_busy_nb),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives the write/reserve/reset inputs and lets the read path settle.
  task automatic applyStimulus(input logic rst, input logic wen, input logic [4:0] waddr,
                               input logic [31:0] wdata, input logic ren, input logic [4:0] raddr);
    reset    = rst;
    wr_en    = wen;
    wr_addr  = waddr;
    wr_data  = wdata;
    rsv_en   = ren;
    rsv_addr = raddr;
    #1;
  endtask

  task automatic setRead(input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] a3);
    rd_addr = {a3, a2, a1, a0};
    #1;
  endtask

  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] data(input int k);
    return rd_data[k*32 +: 32];
  endfunction

  function automatic logic [31:0] busy(input int k);
    return {31'b0, rd_busy[k]};
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    rd_addr = '0;
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    clockEdge();

    // Reset contents: SP holds its init value, others are zero, nothing busy.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    setRead(5'd29, 5'd5, 5'd0, 5'd29);
    checkOutput("rst_sp_data", data(0), 32'h0000_0400);
    checkOutput("rst_r5_data", data(1), 32'h0);
    checkOutput("rst_busy", {28'b0, rd_busy}, 32'h0);
    checkOutput("rst_sp_data_p3", data(3), 32'h0000_0400);
    checkOutput("rst_nb_sp_data", rd_data_nb[31:0], 32'h0000_0400);

    // Same-cycle write bypass versus no-bypass old value.
    setRead(5'd3, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0);
    checkOutput("byp_data", data(0), 32'hDEAD_BEEF);
    checkOutput("byp_busy", busy(0), 32'h0);
    checkOutput("nobyp_old_data", rd_data_nb[31:0], 32'h0);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("wr_persist", data(0), 32'hDEAD_BEEF);
    checkOutput("nobyp_persist", rd_data_nb[31:0], 32'hDEAD_BEEF);

    // Writes and reserves to index 0 are ignored.
    setRead(5'd0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0);
    checkOutput("zero_same_data0", data(0), 32'h0);
    checkOutput("zero_same_data3", data(3), 32'h0);
    checkOutput("zero_same_busy", {28'b0, rd_busy}, 32'h0);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("zero_next_data1", data(1), 32'h0);
    checkOutput("zero_next_busy", {28'b0, rd_busy}, 32'h0);

    // Reservation is only visible after the edge.
    setRead(5'd7, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    checkOutput("rsv7_same_busy", busy(0), 32'h0);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("rsv7_next_busy", busy(0), 32'h1);
    checkOutput("rsv7_nb_busy", {31'b0, rd_busy_nb[0]}, 32'h1);

    // Writeback clears busy: same cycle with bypass, next cycle without.
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h0000_1234, 1'b0, 5'd0);
    checkOutput("wb7_byp_busy", busy(0), 32'h0);
    checkOutput("wb7_byp_data", data(0), 32'h0000_1234);
    checkOutput("wb7_nb_busy_still", {31'b0, rd_busy_nb[0]}, 32'h1);
    checkOutput("wb7_nb_data_old", rd_data_nb[31:0], 32'h0);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("wb7_nb_busy_clr", {31'b0, rd_busy_nb[0]}, 32'h0);
    checkOutput("wb7_nb_data", rd_data_nb[31:0], 32'h0000_1234);

    // Write and reserve to the same index: data lands, busy ends set.
    setRead(5'd9, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h0000_9999, 1'b1, 5'd9);
    checkOutput("wr_rsv9_same_data", data(0), 32'h0000_9999);
    checkOutput("wr_rsv9_same_busy", busy(0), 32'h0);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("wr_rsv9_next_busy", busy(0), 32'h1);
    checkOutput("wr_rsv9_next_data", data(0), 32'h0000_9999);

    // Write and reserve to different indices act independently.
    setRead(5'd10, 5'd11, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd10, 32'h0000_00A5, 1'b1, 5'd11);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("split_r10_data", data(0), 32'h0000_00A5);
    checkOutput("split_r10_busy", busy(0), 32'h0);
    checkOutput("split_r11_data", data(1), 32'h0);
    checkOutput("split_r11_busy", busy(1), 32'h1);

    // Reset beats write/reserve and suppresses bypass.
    setRead(5'd4, 5'd6, 5'd9, 5'd29);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("pre_rst_busy4", busy(0), 32'h1);
    applyStimulus(1'b1, 1'b1, 5'd4, 32'h0000_AAAA, 1'b1, 5'd6);
    checkOutput("rst_no_byp_data", data(0), 32'h0);
    checkOutput("rst_no_byp_busy", busy(0), 32'h1);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("post_rst_r4_data", data(0), 32'h0);
    checkOutput("post_rst_r4_busy", busy(0), 32'h0);
    checkOutput("post_rst_r6_busy", busy(1), 32'h0);
    checkOutput("post_rst_r9_busy", busy(2), 32'h0);
    checkOutput("post_rst_r9_data", data(2), 32'h0);
    checkOutput("post_rst_sp_data", data(3), 32'h0000_0400);

    // All four ports on one index see the same value and busy state.
    setRead(5'd12, 5'd12, 5'd12, 5'd12);
    applyStimulus(1'b0, 1'b1, 5'd12, 32'h0000_0055, 1'b0, 5'd0);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("mp_data%0d", k), data(k), 32'h0000_0055);
    end
    checkOutput("mp_busy_clear", {28'b0, rd_busy}, 32'h0);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("mp_busy_set", {28'b0, rd_busy}, 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
